mem_arbiter: RTL and testbench

- Sits directly downstream of the store buffer and beside the data cache.
- Arbitrates two line-wide requesters onto the single 128-bit memory port:
  - store-buffer writebacks (wMemReq/wAddrMem/wDataMem/wMemAck);
  - data-cache line-fill reads.
- Sequences each transaction through a request/ack FSM, orders same-line read-after-write hazards, and bounds write starvation.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the store buffer, the data-cache fill path, the memory port and mem_arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface mem_arbiter_if;
    logic         wMemReq;
    logic [31:0]  wAddrMem;
    logic [127:0] wDataMem;
    logic         wMemAck;
    logic         rdReq;
    logic [31:0]  rdAddr;
    logic [127:0] rdData;
    logic         rdAck;
    logic         memReq;
    logic         memWe;
    logic [31:0]  memAddr;
    logic [127:0] memWData;
    logic         memAck;
    logic [127:0] memRData;
    logic         busy;
    logic         memErr;

    modport slave (
        input  wMemReq, wAddrMem, wDataMem, rdReq, rdAddr, memAck, memRData,
        output wMemAck, rdData, rdAck, memReq, memWe, memAddr, memWData, busy, memErr
    );

    modport master (
        output wMemReq, wAddrMem, wDataMem, rdReq, rdAddr, memAck, memRData,
        input  wMemAck, rdData, rdAck, memReq, memWe, memAddr, memWData, busy, memErr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates store-buffer writebacks and cache line fills onto one 128-bit memory port.
// Optional WAIT watchdog with sticky memErr is built when MEMARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int unsigned MAX_READ_STREAK = 4,
    parameter int unsigned STREAK_BITS     = 3
`ifdef MEMARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 64
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [31:0] LINE_MASK = ~32'h0000_000F;

    state_e                 state_q, state_d;
    logic [STREAK_BITS-1:0] streak_q, streak_d;
    logic                   gnt_wr_q, gnt_wr_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [127:0]           mem_wdata_q, mem_wdata_d;
    logic                   wr_ack_q, wr_ack_d;
    logic                   rd_ack_q, rd_ack_d;
    logic [127:0]           rd_data_q, rd_data_d;
    logic                   busy_q, busy_d;
    logic                   hazard;
    logic                   pick_wr;

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   mem_err_q, mem_err_d;
`endif

    // Next-state, grant selection and registered output values.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        gnt_wr_d    = gnt_wr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        hazard      = (bus.rdAddr[31:4] == bus.wAddrMem[31:4]);
        pick_wr     = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        mem_err_d   = mem_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.wMemReq || bus.rdReq) begin
                    // A same-line write must land before the fill reads it back.
                    pick_wr     = bus.wMemReq &&
                                  (!bus.rdReq || hazard ||
                                   (streak_q >= STREAK_BITS'(MAX_READ_STREAK)));
                    gnt_wr_d    = pick_wr;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_wr;
                    mem_addr_d  = (pick_wr ? bus.wAddrMem : bus.rdAddr) & LINE_MASK;
                    mem_wdata_d = pick_wr ? bus.wDataMem : '0;
                    busy_d      = 1'b1;
                    state_d     = WAIT;
                    if (!pick_wr && bus.wMemReq) begin
                        if (streak_q < STREAK_BITS'(MAX_READ_STREAK)) begin
                            streak_d = streak_q + STREAK_BITS'(1);
                        end
                    end else begin
                        streak_d = '0;
                    end
`ifdef MEMARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (gnt_wr_q) begin
                        wr_ack_d = 1'b1;
                    end else begin
                        rd_ack_d  = 1'b1;
                        rd_data_d = bus.memRData;
                    end
`ifdef MEMARB_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expiry completes the transaction with zero read data.
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = RESP;
                    if (gnt_wr_q) begin
                        wr_ack_d = 1'b1;
                    end else begin
                        rd_ack_d  = 1'b1;
                        rd_data_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            gnt_wr_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            gnt_wr_q    <= gnt_wr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
`ifdef MEMARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
`endif
        end
    end

    assign bus.memReq   = mem_req_q;
    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWData = mem_wdata_q;
    assign bus.wMemAck  = wr_ack_q;
    assign bus.rdAck    = rd_ack_q;
    assign bus.rdData   = rd_data_q;
    assign bus.busy     = busy_q;
`ifdef MEMARB_TIMEOUT_EN
    assign bus.memErr   = mem_err_q;
`else
    assign bus.memErr   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    mem_arbiter_if bus();

`ifdef MEMARB_TIMEOUT_EN
    mem_arbiter #(.MAX_READ_STREAK(4), .STREAK_BITS(3), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`else
    mem_arbiter #(.MAX_READ_STREAK(4), .STREAK_BITS(3)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wreq;
        logic [31:0]  waddr;
        logic [127:0] wdata;
        logic         rreq;
        logic [31:0]  raddr;
        logic [127:0] rdata;
        int unsigned  delay;
        logic         exp_we;
        logic [31:0]  exp_addr;
        int unsigned  exp_busy;
    } vec_t;

    int n_vec;
    int n_err;
    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        bus.wMemReq = 1'b0;
        bus.rdReq   = 1'b0;
    endtask

    // One table transaction, entered at an IDLE negedge.
    task automatic do_txn(input vec_t v, input int idx);
        int unsigned busy_cnt;
        string tag;
        tag = $sformatf("v%0d", idx);
        bus.wMemReq  = v.wreq;
        bus.wAddrMem = v.waddr;
        bus.wDataMem = v.wdata;
        bus.rdReq    = v.rreq;
        bus.rdAddr   = v.raddr;
        busy_cnt     = 0;
        @(negedge clk);
        check({tag, ".memReq"}, 128'(bus.memReq), 128'(1));
        check({tag, ".memWe"}, 128'(bus.memWe), 128'(v.exp_we));
        check({tag, ".memAddr"}, 128'(bus.memAddr), 128'(v.exp_addr));
        if (v.exp_we) check({tag, ".memWData"}, bus.memWData, v.wdata);
        for (int i = 0; i < int'(v.delay); i++) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        if (bus.busy) busy_cnt++;
        check({tag, ".hold_addr"}, 128'({bus.memReq, bus.memAddr}), 128'({1'b1, v.exp_addr}));
        bus.memAck   = 1'b1;
        bus.memRData = v.rdata;
        @(negedge clk);
        bus.memAck   = 1'b0;
        bus.memRData = {4{32'h0BAD_F00D}};
        if (bus.busy) busy_cnt++;
        check({tag, ".resp_acks"}, 128'({bus.memReq, bus.wMemAck, bus.rdAck}),
              128'({1'b0, v.exp_we, !v.exp_we}));
        if (!v.exp_we) check({tag, ".rdData"}, bus.rdData, v.rdata);
        drop_reqs();
        @(negedge clk);
        if (bus.busy) busy_cnt++;
        check({tag, ".idle_acks"}, 128'({bus.wMemAck, bus.rdAck}), 128'(0));
        check({tag, ".busy_cycles"}, 128'(busy_cnt), 128'(v.exp_busy));
        if (!v.exp_we) check({tag, ".rdData_hold"}, bus.rdData, v.rdata);
    endtask

    // Serve the next memory request with an immediate memAck; returns at the RESP negedge.
    task automatic serve_one(input string name, output logic we, output logic [31:0] addr);
        int n;
        n = 0;
        we = 1'b0;
        addr = '0;
        @(negedge clk);
        while (!bus.memReq && n < 10) begin
            n++;
            @(negedge clk);
        end
        check({name, ".grant_seen"}, 128'(bus.memReq), 128'(1));
        we   = bus.memWe;
        addr = bus.memAddr;
        bus.memAck   = 1'b1;
        bus.memRData = {4{32'h1234_5678}};
        @(negedge clk);
        bus.memAck = 1'b0;
        check({name, ".acks"}, 128'({bus.wMemAck, bus.rdAck}), 128'({we, !we}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        we;
        logic [31:0] addr;
        logic [5:0]  grants;
        int          n;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        bus.wMemReq  = 1'b0;
        bus.wAddrMem = '0;
        bus.wDataMem = '0;
        bus.rdReq    = 1'b0;
        bus.rdAddr   = '0;
        bus.memAck   = 1'b0;
        bus.memRData = '0;

        vecs[0] = '{1'b1, 32'h0000_1008, {16{8'hA5}}, 1'b0, 32'h0, 128'h0, 2, 1'b1, 32'h0000_1000, 4};
        vecs[1] = '{1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_2004, {4{32'hDEAD_BEEF}}, 0, 1'b0, 32'h0000_2000, 2};
        vecs[2] = '{1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_400F, {4{32'hCAFE_0001}}, 1, 1'b0, 32'h0000_4000, 3};
        vecs[3] = '{1'b1, 32'h0000_9000, {16{8'h3C}}, 1'b1, 32'h0000_8000, {4{32'h5555_AAAA}}, 1, 1'b0, 32'h0000_8000, 3};
        vecs[4] = '{1'b1, 32'h0000_301C, {16{8'h77}}, 1'b1, 32'h0000_3010, 128'h0, 0, 1'b1, 32'h0000_3010, 2};
        vecs[5] = '{1'b1, 32'hFFFF_FFF3, {8{16'hBEEF}}, 1'b0, 32'h0, 128'h0, 3, 1'b1, 32'hFFFF_FFF0, 5};

        #12;
        check("reset.outputs", 128'({bus.memReq, bus.memWe, bus.wMemAck, bus.rdAck, bus.busy, bus.memErr}), 128'(0));
        check("reset.memAddr", 128'(bus.memAddr), 128'(0));
        check("reset.rdData", bus.rdData, 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle.no_req", 128'({bus.memReq, bus.busy}), 128'(0));

        foreach (vecs[i]) do_txn(vecs[i], i);

        // memAck while idle is ignored.
        bus.memAck = 1'b1;
        @(negedge clk);
        bus.memAck = 1'b0;
        @(negedge clk);
        check("idle_ack.ignored", 128'({bus.busy, bus.memReq, bus.wMemAck, bus.rdAck}), 128'(0));

        // Same-line hazard: write first, then the held read.
        bus.wMemReq = 1'b1; bus.wAddrMem = 32'h0000_301C; bus.wDataMem = {16{8'h11}};
        bus.rdReq   = 1'b1; bus.rdAddr   = 32'h0000_3010;
        serve_one("hazard1", we, addr);
        check("hazard.first_is_write", 128'({we, addr}), 128'({1'b1, 32'h0000_3010}));
        bus.wMemReq = 1'b0;
        serve_one("hazard2", we, addr);
        check("hazard.second_is_read", 128'({we, addr}), 128'({1'b0, 32'h0000_3010}));
        bus.rdReq = 1'b0;

        // Starvation bound: four reads, forced write, then reads resume.
        bus.wMemReq = 1'b1; bus.wAddrMem = 32'h0000_5000;
        bus.rdReq   = 1'b1; bus.rdAddr   = 32'h0000_A000;
        grants = '0;
        for (int g = 0; g < 6; g++) begin
            serve_one($sformatf("starve%0d", g), we, addr);
            grants[g] = we;
            if (we) bus.wAddrMem = bus.wAddrMem + 32'h100;
            else    bus.rdAddr   = bus.rdAddr + 32'h100;
        end
        check("starve.grant_order", 128'(grants), 128'(6'b010000));
        drop_reqs();
        @(negedge clk);

        // Asynchronous reset during WAIT.
        bus.wMemReq = 1'b1; bus.wAddrMem = 32'h0000_6004; bus.wDataMem = {16{8'h5A}};
        @(negedge clk);
        check("rst_mid.in_wait", 128'({bus.memReq, bus.busy}), 128'(2'b11));
        #2 rst = 1'b0;
        #1;
        check("rst_mid.async_clear", 128'({bus.memReq, bus.busy, bus.wMemAck, bus.rdAck}), 128'(0));
        check("rst_mid.rdData", bus.rdData, 128'(0));
        @(negedge clk);
        rst = 1'b1;
        serve_one("rst_regrant", we, addr);
        check("rst_mid.regrant", 128'({we, addr}), 128'({1'b1, 32'h0000_6000}));
        drop_reqs();
        @(negedge clk);
        check("memErr.clear", 128'(bus.memErr), 128'(0));

`ifdef MEMARB_TIMEOUT_EN
        bus.rdReq = 1'b1; bus.rdAddr = 32'h0000_B000;
        serve_one("pre_timeout", we, addr);
        bus.rdReq = 1'b0;
        @(negedge clk);
        check("pre_timeout.rdData", bus.rdData, {4{32'h1234_5678}});
        bus.rdReq = 1'b1; bus.rdAddr = 32'h0000_7000;
        @(negedge clk);
        n = 0;
        while (bus.memReq && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("timeout.wait_cycles", 128'(n), 128'(8));
        check("timeout.resp", 128'({bus.rdAck, bus.wMemAck, bus.memErr}), 128'(3'b101));
        check("timeout.rdData", bus.rdData, 128'(0));
        bus.rdReq = 1'b0;
        @(negedge clk);
        check("timeout.idle_sticky", 128'({bus.busy, bus.rdAck, bus.memErr}), 128'(3'b001));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
